// File: rtl/unidade_controle_jogo.sv
// Game control unit: sequences display, player input, compare and round advance.
// Moore FSM with registered outputs decoded from the next state.
module unidade_controle_jogo #(
    parameter int N_RODADAS = 16,
    parameter int ROUND_W   = 4,
    parameter int TIMEOUT   = 5000,
    parameter int T_MOSTRA  = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               jogada,
    input  logic               igual,
    input  logic               fimE,
    input  logic               modo,
    output logic               zeraE,
    output logic               contaE,
    output logic               zeraR,
    output logic               registraR,
    output logic               acende,
    output logic [ROUND_W-1:0] rodada,
    output logic               pronto,
    output logic               acertou,
    output logic               errou,
    output logic               errou_timeout,
    output logic [3:0]         db_estado
);

    localparam int TMAX = (TIMEOUT > T_MOSTRA) ? TIMEOUT : T_MOSTRA;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [ROUND_W-1:0] ULT = ROUND_W'(N_RODADAS - 1);

    typedef enum logic [3:0] {
        inicial       = 4'h0,
        preparacao    = 4'h1,
        inicia_rodada = 4'h2,
        mostra        = 4'h3,
        mostra_prox   = 4'h4,
        inicia_jogada = 4'h5,
        espera        = 4'h6,
        registra      = 4'h7,
        compara       = 4'h8,
        proxima       = 4'h9,
        final_acerto  = 4'hA,
        ultima_jogada = 4'hB,
        final_timeout = 4'hC,
        prox_rodada   = 4'hD,
        final_erro    = 4'hE
    } estado_t;

    estado_t       estado, prox;
    logic [TW-1:0] tempo;
    logic          modo_l;
    logic          fim_mostra, fim_tempo, conta;

    assign fim_mostra = (tempo == TW'(T_MOSTRA - 1));
    assign fim_tempo  = modo_l && (tempo == TW'(TIMEOUT - 1));
    assign conta      = (estado == mostra) || (estado == espera && modo_l);

    // bits: zeraE contaE zeraR registraR acende pronto acertou errou errou_timeout db[3:0]
    function automatic logic [12:0] decode(estado_t e);
        logic [12:0] o;
        o      = '0;
        o[3:0] = e;
        case (e)
            inicial:       begin o[12] = 1'b1; o[10] = 1'b1; end
            preparacao:    o[10] = 1'b1;
            inicia_rodada: o[12] = 1'b1;
            mostra:        o[8]  = 1'b1;
            mostra_prox:   o[11] = 1'b1;
            inicia_jogada: o[12] = 1'b1;
            espera:        ;
            registra:      o[9]  = 1'b1;
            compara:       ;
            proxima:       o[11] = 1'b1;
            ultima_jogada: ;
            prox_rodada:   ;
            final_acerto:  begin o[7] = 1'b1; o[6] = 1'b1; end
            final_erro:    begin o[7] = 1'b1; o[5] = 1'b1; end
            final_timeout: begin o[7] = 1'b1; o[5] = 1'b1; o[4] = 1'b1; end
            default:       o = 13'h000F;
        endcase
        return o;
    endfunction

    always_comb begin
        prox = estado;
        case (estado)
            inicial:       if (iniciar) prox = preparacao;
            preparacao:    prox = inicia_rodada;
            inicia_rodada: prox = mostra;
            mostra:        if (fim_mostra) prox = fimE ? inicia_jogada : mostra_prox;
            mostra_prox:   prox = mostra;
            inicia_jogada: prox = espera;
            espera: begin
                if (fim_tempo)   prox = final_timeout;
                else if (jogada) prox = registra;
            end
            registra:      prox = compara;
            compara: begin
                if (!igual)     prox = final_erro;
                else if (fimE)  prox = ultima_jogada;
                else            prox = proxima;
            end
            proxima:       prox = espera;
            ultima_jogada: prox = (rodada == ULT) ? final_acerto : prox_rodada;
            prox_rodada:   prox = inicia_rodada;
            final_acerto,
            final_erro,
            final_timeout: if (iniciar) prox = preparacao;
            default:       prox = inicial;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= inicial;
            tempo  <= '0;
            rodada <= '0;
            modo_l <= 1'b0;
            {zeraE, contaE, zeraR, registraR, acende, pronto,
             acertou, errou, errou_timeout, db_estado} <= decode(inicial);
        end else begin
            estado <= prox;
            // timer restarts on every state change
            tempo  <= (prox != estado || !conta) ? '0 : tempo + 1'b1;
            if (estado == preparacao) begin
                rodada <= '0;
                modo_l <= modo;
            end else if (estado == prox_rodada) begin
                rodada <= rodada + 1'b1;
            end
            {zeraE, contaE, zeraR, registraR, acende, pronto,
             acertou, errou, errou_timeout, db_estado} <= decode(prox);
        end
    end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: table vectors, directed games, random games
// checked cycle by cycle against a phase-level trace model.
module tb_unidade_controle_jogo;

    localparam int N  = 2;
    localparam int RW = 4;
    localparam int TO = 4;
    localparam int TM = 2;

    logic          clock = 1'b0;
    logic          reset, iniciar, jogada, igual, fimE, modo;
    logic          zeraE, contaE, zeraR, registraR, acende;
    logic          pronto, acertou, errou, errou_timeout;
    logic [RW-1:0] rodada;
    logic [3:0]    db_estado;

    unidade_controle_jogo #(
        .N_RODADAS(N), .ROUND_W(RW), .TIMEOUT(TO), .T_MOSTRA(TM)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .modo(modo),
        .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .registraR(registraR),
        .acende(acende), .rodada(rodada), .pronto(pronto), .acertou(acertou),
        .errou(errou), .errou_timeout(errou_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          ini, jog, igu, fim, mdo;
        logic [3:0]    code;
        logic [RW-1:0] rod;
    } step_t;

    step_t         tab [12];
    step_t         q [$];
    int            total = 0;
    int            bad   = 0;
    logic [RW-1:0] rod_m;
    logic [3:0]    last;

    function automatic logic [16:0] exp_o(logic [3:0] c, logic [RW-1:0] r);
        logic ze, ce, zr, rr, ac, pr, at, er, et;
        ze = (c == 4'h0) || (c == 4'h2) || (c == 4'h5);
        ce = (c == 4'h4) || (c == 4'h9);
        zr = (c == 4'h0) || (c == 4'h1);
        rr = (c == 4'h7);
        ac = (c == 4'h3);
        pr = (c == 4'hA) || (c == 4'hE) || (c == 4'hC);
        at = (c == 4'hA);
        er = (c == 4'hE) || (c == 4'hC);
        et = (c == 4'hC);
        return {ze, ce, zr, rr, ac, pr, at, er, et, c, r};
    endfunction

    function automatic logic [16:0] act_o();
        return {zeraE, contaE, zeraR, registraR, acende, pronto, acertou,
                errou, errou_timeout, db_estado, rodada};
    endfunction

    task automatic check(string nm, logic [16:0] e);
        total++;
        if (act_o() !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (db_estado=%h rodada=%0d)",
                     nm, act_o(), e, db_estado, rodada);
        end
    endtask

    // at a negedge: check the state being shown, then drive its inputs
    task automatic apply(step_t s, string nm);
        check(nm, exp_o(s.code, s.rod));
        iniciar = s.ini;
        jogada  = s.jog;
        igual   = s.igu;
        fimE    = s.fim;
        modo    = s.mdo;
        @(negedge clock);
    endtask

    function automatic logic pick(int v);
        return (v < 0) ? 1'($urandom_range(0, 1)) : v[0];
    endfunction

    function automatic void push(int c, int ini, int jog, int igu, int fim, int mdo);
        step_t s;
        s.code = 4'(c);
        s.rod  = rod_m;
        s.ini  = pick(ini);
        s.jog  = pick(jog);
        s.igu  = pick(igu);
        s.fim  = pick(fim);
        s.mdo  = pick(mdo);
        q.push_back(s);
    endfunction

    // errp: -1 all correct, -2 random mistakes, else index of the wrong play
    function automatic void build(logic [3:0] start, logic m, int kfix, int errp);
        int gp = 0;
        push(start, 1, -1, -1, -1, -1);
        push(1, -1, -1, -1, -1, m);
        rod_m = '0;
        for (int r = 0; r < N; r++) begin
            push(2, -1, -1, -1, -1, -1);
            for (int e = 0; e <= r; e++) begin
                for (int t = 0; t < TM; t++)
                    push(3, -1, -1, -1, (t == TM - 1) ? int'(e == r) : -1, -1);
                if (e < r) push(4, -1, -1, -1, -1, -1);
            end
            push(5, -1, -1, -1, -1, -1);
            for (int p = 0; p <= r; p++) begin
                int  k;
                bit  ig;
                k  = (kfix > 0) ? kfix : int'($urandom_range(1, 5));
                ig = 1'b1;
                if (gp == errp) ig = 1'b0;
                if (errp == -2 && $urandom_range(0, 7) == 0) ig = 1'b0;
                if (m && k >= TO) begin
                    for (int c = 1; c <= TO; c++)
                        push(6, -1, int'(c == k), -1, -1, -1);
                    push(12, 0, -1, -1, -1, -1);
                    last = 4'hC;
                    return;
                end
                for (int c = 1; c <= k; c++)
                    push(6, -1, int'(c == k), -1, -1, -1);
                push(7, -1, -1, -1, -1, -1);
                push(8, -1, -1, int'(ig), int'(p == r), -1);
                if (!ig) begin
                    push(14, 0, -1, -1, -1, -1);
                    last = 4'hE;
                    return;
                end
                if (p < r) push(9, -1, -1, -1, -1, -1);
                gp++;
            end
            push(11, -1, -1, -1, -1, -1);
            if (r == N - 1) begin
                push(10, 0, -1, -1, -1, -1);
                last = 4'hA;
                return;
            end
            push(13, -1, -1, -1, -1, -1);
            rod_m = rod_m + 1'b1;
        end
    endfunction

    task automatic run(string nm);
        foreach (q[i]) apply(q[i], nm);
        q.delete();
    endtask

    initial begin
        int idx;
        // round 0, wrong play: iniciar .. mostra x2 .. espera .. compara(igual=0)
        tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0};
        tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'd0};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'd0};
        tab[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'd0};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'd0};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd0};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'd0};
        tab[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 4'd0};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 4'd0};
        tab[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 4'd0};
        tab[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0};

        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0;
        igual = 1'b0; fimE = 1'b0; modo = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_state", exp_o(4'h0, 4'd0));
        iniciar = 1'b1;
        @(negedge clock);
        check("reset_over_iniciar", exp_o(4'h0, 4'd0));
        reset = 1'b0; iniciar = 1'b0;

        for (int i = 0; i < 12; i++) apply(tab[i], "table");
        last  = 4'hE;
        rod_m = '0;

        build(last, 1'b0, 1, -1);       run("full_win");
        build(last, 1'b1, TO + 1, -1);  run("timeout_idle");
        build(last, 1'b1, TO, -1);      run("timeout_vs_jogada");
        build(last, 1'b0, 100, -1);     run("no_timeout_modo0");
        build(last, 1'b1, 2, 1);        run("wrong_round1");

        // reset during round-1 display, then a fresh game with the other modo
        build(last, 1'b1, 1, -1);
        idx = 0;
        foreach (q[i]) if (idx == 0 && q[i].code == 4'h3 && q[i].rod == 4'd1) idx = i;
        for (int i = 0; i <= idx; i++) apply(q[i], "pre_reset");
        q.delete();
        reset = 1'b1;
        @(negedge clock);
        check("mid_game_reset", exp_o(4'h0, 4'd0));
        reset = 1'b0;
        rod_m = '0;
        build(4'h0, 1'b0, 5, -1);       run("restart_after_reset");

        for (int g = 0; g < 40; g++) begin
            build(last, 1'($urandom_range(0, 1)), 0, -2);
            run("random_game");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
